// File: rtl/ascon_text_block_loader.sv
// Packs a 32-bit valid/ready text stream into 128-bit Ascon data blocks and
// issues one process_en strobe per block, ending with a partial or pad-only block.
module ascon_text_block_loader #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len_i,
    input  logic             mode_i,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             proc_ready,
    output logic             process_en,
    output logic             process_mode_sel,
    output logic [LEN_W-1:0] text_length,
    output logic [LEN_W-1:0] text_position,
    output logic [127:0]     data_in,
    output logic             last_blk,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       wcnt;
    logic [LEN_W-1:0] rem;
    logic [2:0]       words_needed;
    logic [31:0]      masked;
    logic             accept;

    assign rem          = text_length - text_position;
    assign words_needed = (rem >= 32'd16) ? 3'd4 : 3'(({1'b0, rem[3:0]} + 5'd3) >> 2);
    // Gated by state so the reset/idle view of every output is zero.
    assign last_blk     = (state != IDLE) && (rem < 32'd16);
    assign s_ready      = (state == LOAD);
    assign accept       = s_valid && s_ready;
    assign process_en   = (state == ISSUE) && proc_ready;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // Bytes at or past the end of the message are written as zero.
    always_comb begin
        masked = '0;
        for (int b = 0; b < 4; b++) begin
            if (!last_blk || ({28'd0, wcnt[1:0], 2'(b)} < rem))
                masked[31-8*b -: 8] = s_data[31-8*b -: 8];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (len_i == '0) ? ISSUE : LOAD;
            LOAD:  if (accept && (3'(wcnt + 3'd1) == words_needed)) state_nx = ISSUE;
            ISSUE: if (proc_ready) begin
                if (last_blk)              state_nx = DONE;
                else if (rem == 32'd16)    state_nx = ISSUE;
                else                       state_nx = LOAD;
            end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wcnt             <= '0;
            text_length      <= '0;
            text_position    <= '0;
            data_in          <= '0;
            process_mode_sel <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    text_length      <= len_i;
                    process_mode_sel <= mode_i;
                    text_position    <= '0;
                    data_in          <= '0;
                    wcnt             <= '0;
                end
                LOAD: if (accept) begin
                    case (wcnt[1:0])
                        2'd0: data_in[127:96] <= masked;
                        2'd1: data_in[95:64]  <= masked;
                        2'd2: data_in[63:32]  <= masked;
                        default: data_in[31:0] <= masked;
                    endcase
                    wcnt <= 3'(wcnt + 3'd1);
                end
                ISSUE: if (proc_ready && !last_blk) begin
                    text_position <= text_position + 32'd16;
                    data_in       <= '0;
                    wcnt          <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_text_block_loader.sv
// Directed bench for ascon_text_block_loader: block packing, masking, padding,
// backpressure, mid-message reset and start-while-busy.
module tb_ascon_text_block_loader;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         start = 0;
    logic [31:0]  len_i = 0;
    logic         mode_i = 0;
    logic [31:0]  s_data = 0;
    logic         s_valid = 0;
    logic         s_ready;
    logic         proc_ready = 1;
    logic         process_en;
    logic         process_mode_sel;
    logic [31:0]  text_length;
    logic [31:0]  text_position;
    logic [127:0] data_in;
    logic         last_blk;
    logic         busy;
    logic         done;

    ascon_text_block_loader #(.LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_i(len_i), .mode_i(mode_i),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .proc_ready(proc_ready), .process_en(process_en),
        .process_mode_sel(process_mode_sel), .text_length(text_length),
        .text_position(text_position), .data_in(data_in), .last_blk(last_blk),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Monitor: records every issued block, done pulse and handshake.
    int           cyc = 0, npulse = 0, ndone = 0, nacc = 0, nrdy = 0, done_cyc = 0;
    logic [31:0]  pos_q[$];
    logic [127:0] dat_q[$];
    logic         last_q[$];
    int           cyc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (process_en) begin
            pos_q.push_back(text_position);
            dat_q.push_back(data_in);
            last_q.push_back(last_blk);
            cyc_q.push_back(cyc);
            npulse++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (s_valid && s_ready) nacc++;
        if (s_ready) nrdy++;
    end

    int total = 0, fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] len, input logic mode);
        @(negedge clk);
        start = 1; len_i = len; mode_i = mode;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        s_data = w; s_valid = 1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 128'(n), 128'd0);
        @(posedge clk);
        #1 s_valid = 0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (ndone == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 128'(ndone - d0), 128'd1);
        @(negedge clk);
    endtask

    initial begin
        int b, d, a, r;

        // Reset state
        #12;
        chk("rst_s_ready", 128'(s_ready), 0);
        chk("rst_process_en", 128'(process_en), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_done", 128'(done), 0);
        chk("rst_last_blk", 128'(last_blk), 0);
        chk("rst_text_length", 128'(text_length), 0);
        chk("rst_text_position", 128'(text_position), 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_mode", 128'(process_mode_sel), 0);
        @(negedge clk) rst_n = 1;

        // len=32: two full blocks plus pad-only block
        b = npulse; d = ndone; a = nacc;
        do_start(32, 0);
        send_word(32'h10111213); send_word(32'h14151617);
        send_word(32'h18191a1b); send_word(32'h1c1d1e1f);
        send_word(32'h20212223); send_word(32'h24252627);
        send_word(32'h28292a2b); send_word(32'h2c2d2e2f);
        wait_done(d);
        chk("l32_pulses", 128'(npulse - b), 3);
        chk("l32_words", 128'(nacc - a), 8);
        chk("l32_pos0", 128'(pos_q[b]), 0);
        chk("l32_pos1", 128'(pos_q[b+1]), 16);
        chk("l32_pos2", 128'(pos_q[b+2]), 32);
        chk("l32_dat0", dat_q[b], 128'h10111213_14151617_18191a1b_1c1d1e1f);
        chk("l32_dat1", dat_q[b+1], 128'h20212223_24252627_28292a2b_2c2d2e2f);
        chk("l32_dat2", dat_q[b+2], 0);
        chk("l32_last0", 128'(last_q[b]), 0);
        chk("l32_last2", 128'(last_q[b+2]), 1);
        chk("l32_done_lat", 128'(done_cyc - cyc_q[b+2]), 1);
        chk("l32_len_hold", 128'(text_length), 32);
        chk("l32_pos_hold", 128'(text_position), 32);
        chk("l32_idle", 128'(busy), 0);

        // len=5: masked partial block, decrypt
        b = npulse; d = ndone; a = nacc;
        do_start(5, 1);
        send_word(32'hA1A2A3A4); send_word(32'hB1B2B3B4);
        wait_done(d);
        chk("l5_pulses", 128'(npulse - b), 1);
        chk("l5_words", 128'(nacc - a), 2);
        chk("l5_pos", 128'(pos_q[b]), 0);
        chk("l5_dat", dat_q[b], 128'hA1A2A3A4_B1000000_00000000_00000000);
        chk("l5_last", 128'(last_q[b]), 1);
        chk("l5_mode", 128'(process_mode_sel), 1);

        // len=0: pad-only block without any word accepted
        b = npulse; d = ndone; r = nrdy;
        do_start(0, 0);
        wait_done(d);
        chk("l0_no_ready", 128'(nrdy - r), 0);
        chk("l0_pulses", 128'(npulse - b), 1);
        chk("l0_dat", dat_q[b], 0);
        chk("l0_pos", 128'(pos_q[b]), 0);
        chk("l0_last", 128'(last_q[b]), 1);

        // len=20 with issue backpressure
        proc_ready = 0;
        b = npulse; d = ndone;
        do_start(20, 0);
        send_word(32'h01020304); send_word(32'h05060708);
        send_word(32'h090a0b0c); send_word(32'h0d0e0f10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_process_en", 128'(process_en), 0);
            chk("bp_s_ready", 128'(s_ready), 0);
            chk("bp_data_in", data_in, 128'h01020304_05060708_090a0b0c_0d0e0f10);
        end
        @(posedge clk);
        #1 proc_ready = 1;
        #1 chk("bp_release_pulse", 128'(process_en), 1);
        send_word(32'hC0C1C2C3);
        wait_done(d);
        chk("l20_pulses", 128'(npulse - b), 2);
        chk("l20_pos1", 128'(pos_q[b+1]), 16);
        chk("l20_dat1", dat_q[b+1], 128'hC0C1C2C3_00000000_00000000_00000000);
        chk("l20_last1", 128'(last_q[b+1]), 1);

        // Reset mid-LOAD, then a fresh len=16 message
        b = npulse; d = ndone;
        do_start(64, 1);
        send_word(32'hDEADBEEF); send_word(32'hCAFEF00D);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_s_ready", 128'(s_ready), 0);
        chk("mid_rst_busy", 128'(busy), 0);
        chk("mid_rst_data_in", data_in, 0);
        chk("mid_rst_len", 128'(text_length), 0);
        chk("mid_rst_mode", 128'(process_mode_sel), 0);
        @(negedge clk) rst_n = 1;
        chk("mid_rst_no_pulse", 128'(npulse - b), 0);
        do_start(16, 0);
        send_word(32'h30313233); send_word(32'h34353637);
        send_word(32'h38393a3b); send_word(32'h3c3d3e3f);
        wait_done(d);
        chk("l16_pulses", 128'(npulse - b), 2);
        chk("l16_dat0", dat_q[b], 128'h30313233_34353637_38393a3b_3c3d3e3f);
        chk("l16_last0", 128'(last_q[b]), 0);
        chk("l16_pos1", 128'(pos_q[b+1]), 16);
        chk("l16_dat1", dat_q[b+1], 0);

        // start while busy is ignored
        b = npulse; d = ndone;
        do_start(8, 1);
        send_word(32'h55667788);
        do_start(99, 0);
        chk("busy_mode_kept", 128'(process_mode_sel), 1);
        chk("busy_len_kept", 128'(text_length), 8);
        send_word(32'h99aabbcc);
        wait_done(d);
        chk("busy_pulses", 128'(npulse - b), 1);
        chk("busy_dat", dat_q[b], 128'h55667788_99aabbcc_00000000_00000000);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
